// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display path.
package hex_disp_pkg;

  // Which half of a wide value is currently on the six-digit display.
  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_e;

  localparam int DISP_W    = 32;  // width of the word handed to the decoder
  localparam int DIGITS    = 6;   // hex digits physically available
  localparam int PAGE_BITS = 24;  // bits that fit on those digits (DIGITS * 4)

endpackage : hex_disp_pkg

// File: rtl/page_timer.sv
// Mod-N dwell timer. tick marks the terminal count while enabled; clr restarts
// the count and overrides en.
module page_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == TERM);

  // Next count: clear first, otherwise count up and wrap on the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : page_timer

// File: rtl/hex_val_pager.sv
// Captures a 32-bit debug value and pages it onto a six-digit hex display:
// narrow values are shown directly, wide values alternate LO/HI pages.
module hex_val_pager
  import hex_disp_pkg::*;
#(
  parameter int PAGE_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] in_val,
  input  logic              in_valid,
  input  logic              hold,
  output logic [DISP_W-1:0] disp_val,
  output logic              page_hi,
  output logic              wide
);

  logic [DISP_W-1:0] cap_val_q;
  logic [DISP_W-1:0] cap_val_d;
  page_e             state_q;
  page_e             state_d;
  logic [DISP_W-1:0] disp_q;
  logic [DISP_W-1:0] disp_d;
  logic              page_hi_q;
  logic              page_hi_d;
  logic              wide_q;

  logic capture;
  logic wide_n;
  logic tick;

  assign capture = in_valid && !hold;
  assign wide_n  = |cap_val_q[DISP_W-1:PAGE_BITS];

  // Timer only runs while a wide value is held; a new capture or a narrow
  // value pins it at zero so every fresh value gets a full LO dwell.
  page_timer #(
    .N(PAGE_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (wide_n),
    .clr (capture || !wide_n),
    .tick(tick)
  );

  // Capture register and page state next values; capture beats timer expiry.
  always_comb begin
    cap_val_d = cap_val_q;
    state_d   = state_q;
    if (capture) begin
      cap_val_d = in_val;
      state_d   = PAGE_LO;
    end else if (!wide_n) begin
      state_d = PAGE_LO;
    end else if (tick) begin
      state_d = (state_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
    end
  end

  // Display word for the page currently selected.
  always_comb begin
    disp_d    = {8'h00, cap_val_q[PAGE_BITS-1:0]};
    page_hi_d = 1'b0;
    if (state_q == PAGE_HI) begin
      disp_d    = {8'h00, cap_val_q[DISP_W-1:PAGE_BITS], 16'h0000};
      page_hi_d = 1'b1;
    end
  end

  // State, capture and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val_q <= '0;
      state_q   <= PAGE_LO;
      disp_q    <= '0;
      page_hi_q <= 1'b0;
      wide_q    <= 1'b0;
    end else begin
      cap_val_q <= cap_val_d;
      state_q   <= state_d;
      disp_q    <= disp_d;
      page_hi_q <= page_hi_d;
      wide_q    <= wide_n;
    end
  end

  assign disp_val = disp_q;
  assign page_hi  = page_hi_q;
  assign wide     = wide_q;

endmodule : hex_val_pager

// File: tb/tb_hex_val_pager.sv
// Self-checking bench for hex_val_pager with a short page dwell.
module tb_hex_val_pager;

  localparam int PC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_val;
  logic        in_valid;
  logic        hold;
  logic [31:0] disp_val;
  logic        page_hi;
  logic        wide;

  int errors = 0;
  int checks = 0;

  // Reference model: the last accepted value and how many cycles it has
  // been paging since it was captured.
  logic [31:0] m_cap = 32'h0;
  int          m_age = 0;

  logic [31:0] e_disp;
  logic        e_hi;
  logic        e_wide;

  hex_val_pager #(.PAGE_CYCLES(PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_val  (in_val),
    .in_valid(in_valid),
    .hold    (hold),
    .disp_val(disp_val),
    .page_hi (page_hi),
    .wide    (wide)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, predict from the model, compare.
  task automatic step(input logic r, input logic v, input logic h, input logic [31:0] val);
    bit odd;
    rst = r; in_valid = v; hold = h; in_val = val;
    @(posedge clk);
    if (r) begin
      e_disp = 32'h0; e_hi = 1'b0; e_wide = 1'b0;
      m_cap = 32'h0; m_age = 0;
    end else begin
      e_wide = (m_cap >= 32'h0100_0000);
      odd    = e_wide && (((m_age / PC) % 2) == 1);
      e_hi   = odd;
      e_disp = odd ? ((m_cap >> 24) << 16) : (m_cap % 32'h0100_0000);
      if (v && !h) begin
        m_cap = val; m_age = 0;
      end else if (e_wide) begin
        m_age = (m_age + 1) % (2 * PC);
      end else begin
        m_age = 0;
      end
    end
    #1;
    chk("disp_val", disp_val, e_disp);
    chk("page_hi", {31'h0, page_hi}, {31'h0, e_hi});
    chk("wide", {31'h0, wide}, {31'h0, e_wide});
    $display("t=%0t rst=%0b v=%0b h=%0b in=%08h disp=%08h hi=%0b wide=%0b", $time,
             r, v, h, val, disp_val, page_hi, wide);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Idle until the model reaches paging age a (bounded).
  task automatic wait_age(input int a, input string tag);
    int k;
    k = 0;
    while (m_age != a && k < 4 * PC) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      k++;
    end
    checks++;
    if (m_age != a) begin
      errors++;
      $display("FAIL %s: age %0d never reached, at %0d", tag, a, m_age);
    end
  endtask

  initial begin
    logic [31:0] rv;
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0; in_val = 32'h0;

    // Reset with a capture attempt active.
    step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_disp", disp_val, 32'h0);

    // Narrow value.
    step(1'b0, 1'b1, 1'b0, 32'h00AB_CDEF);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("narrow_disp", disp_val, 32'h00AB_CDEF);
    idle(20);
    chk("narrow_hi", {31'h0, page_hi}, 32'h0);

    // Wide value: fixed LO/HI pattern.
    step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("wide_pattern", disp_val, ((k / PC) % 2 == 1) ? 32'h00DE_0000 : 32'h00AD_BEEF);
      chk("wide_flag", {31'h0, wide}, 32'h1);
    end

    // Capture colliding with HI->LO terminal count.
    wait_age(2 * PC - 1, "sync_hi_end");
    step(1'b0, 1'b1, 1'b0, 32'h0100_0000);
    for (int k = 0; k < PC; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("coll_hi_lo", {page_hi, disp_val[30:0]}, 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("coll_hi_next", disp_val, 32'h0001_0000);

    // Capture colliding with LO->HI terminal count.
    wait_age(PC - 1, "sync_lo_end");
    step(1'b0, 1'b1, 1'b0, 32'h0100_0000);
    for (int k = 0; k < PC; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("coll_lo_stay", {31'h0, page_hi}, 32'h0);
    end

    // Hold freezes the value; paging carries on.
    step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0042);
    for (int k = 0; k < 2 * PC; k++) step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("hold_wide", {31'h0, wide}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0042);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("release_disp", disp_val, 32'h0000_0042);
    chk("release_hi", {31'h0, page_hi}, 32'h0);

    // Boundary values.
    step(1'b0, 1'b1, 1'b0, 32'h00FF_FFFF);
    idle(PC + 2);
    chk("bound_narrow", {wide, disp_val[30:0]}, 32'h00FF_FFFF);
    step(1'b0, 1'b1, 1'b0, 32'h0100_0000);
    idle(PC + 2);
    chk("bound_wide", {31'h0, page_hi}, 32'h1);

    // Reset in the middle of a HI page (count 2).
    wait_age(PC + 2, "sync_mid_hi");
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_disp", {page_hi, wide, disp_val[29:0]}, 32'h0);
    idle(3);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: rv = 32'h00FF_FFFF + $urandom_range(0, 1);
        1: rv = $urandom_range(0, 32'h00FF_FFFF);
        default: rv = $urandom;
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hex_val_pager
